// File: rtl/wb_mailbox_fifo_if.sv
// Wishbone slave bus (EOS S3 WBs_* naming) plus the fabric-side drain stream
// of the mailbox FIFO.
//   WBs_ADR/CYC/STB/WE/RD/BYTE_STB/WR_DAT : bus request, driven by the host side
//   WBs_RD_DAT/WBs_ACK                    : registered read data and acknowledge
//   M_DATA/M_VALID                        : stream head word and valid, from the mailbox
//   M_READY                               : stream ready, from the consumer
interface wb_mailbox_fifo_if;
  logic [16:0] WBs_ADR;
  logic        WBs_CYC;
  logic        WBs_STB;
  logic        WBs_WE;
  logic        WBs_RD;
  logic [3:0]  WBs_BYTE_STB;
  logic [31:0] WBs_WR_DAT;
  logic [31:0] WBs_RD_DAT;
  logic        WBs_ACK;
  logic [31:0] M_DATA;
  logic        M_VALID;
  logic        M_READY;

  modport slave (
    input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
    output WBs_RD_DAT, WBs_ACK,
    output M_DATA, M_VALID,
    input  M_READY
  );

  modport master (
    output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
    input  WBs_RD_DAT, WBs_ACK,
    input  M_DATA, M_VALID,
    output M_READY
  );
endinterface

// File: rtl/wb_mailbox_fifo.sv
// Mailbox FIFO behind a Wishbone slave. The host pushes 32-bit words through
// the FIFO_DATA register; fabric logic drains them via the ready/valid stream.
// Ports:
//   WB_CLK : bus/fabric clock
//   WB_RST : asynchronous active-high reset
//   bus    : Wishbone slave + stream (see wb_mailbox_fifo_if)
//   IRQ    : registered level interrupt, IRQ_EN & (OVF | empty)
// Register map (ADR[4:2]): 0 ID, 1 CTRL, 2 STATUS, 3 FIFO_DATA, 4 SCRATCH,
// 5..7 reserved (read 0, writes ignored, still acked).
module wb_mailbox_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] ID_VALUE   = 32'h5146_4946
) (
  input  logic              WB_CLK,
  input  logic              WB_RST,
  wb_mailbox_fifo_if.slave  bus,
  output logic              IRQ
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  en, irq_en, ovf;
  logic [31:0]           scratch;
  logic                  ack;
  logic [31:0]           rd_dat;
  logic [31:0]           status;
  logic [31:0]           rd_mux;

  logic       xfer, wr, rd;
  logic [2:0] addr;
  logic       empty, full, m_valid, pop, push, push_ok, clr, ovf_clr;

  // The !ack term splits back-to-back strobes into one transfer every other cycle.
  assign xfer    = bus.WBs_CYC & bus.WBs_STB & ~ack;
  assign wr      = xfer & bus.WBs_WE;
  assign rd      = xfer & ~bus.WBs_WE;
  assign addr    = bus.WBs_ADR[4:2];

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign m_valid = ~empty & en;
  assign clr     = wr && (addr == 3'd1) && bus.WBs_BYTE_STB[0] && bus.WBs_WR_DAT[2];
  // CLR wins over a pop in the same cycle.
  assign pop     = m_valid & bus.M_READY & ~clr;
  assign push    = wr && (addr == 3'd3);
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign push_ok = push & (~full | pop);
  assign ovf_clr = wr && (addr == 3'd2) && bus.WBs_BYTE_STB[2] && bus.WBs_WR_DAT[18];

  assign bus.M_DATA     = mem[rd_ptr];
  assign bus.M_VALID    = m_valid;
  assign bus.WBs_ACK    = ack;
  assign bus.WBs_RD_DAT = rd_dat;

  logic unused_bits;
  assign unused_bits = ^{bus.WBs_ADR[16:5], bus.WBs_ADR[1:0], bus.WBs_RD};

  always_comb begin
    status                 = '0;
    status[DEPTH_LOG2:0]   = count;
    status[16]             = empty;
    status[17]             = full;
    status[18]             = ovf;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      3'd0:    rd_mux = ID_VALUE;
      3'd1:    rd_mux = {30'd0, irq_en, en};
      3'd2:    rd_mux = status;
      3'd4:    rd_mux = scratch;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      ack    <= 1'b0;
      rd_dat <= '0;
    end else begin
      ack    <= xfer;
      rd_dat <= rd ? rd_mux : '0;
    end
  end

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      scratch <= '0;
    end else if (wr) begin
      if (addr == 3'd1 && bus.WBs_BYTE_STB[0]) begin
        en     <= bus.WBs_WR_DAT[0];
        irq_en <= bus.WBs_WR_DAT[1];
      end
      if (addr == 3'd4) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.WBs_BYTE_STB[b]) scratch[8*b +: 8] <= bus.WBs_WR_DAT[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (push_ok && !pop)      count <= count + 1'b1;
        else if (pop && !push_ok) count <= count - 1'b1;
      end
      if (push && !push_ok) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

  // Storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge WB_CLK) begin
    if (push_ok) mem[wr_ptr] <= bus.WBs_WR_DAT;
  end

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) IRQ <= 1'b0;
    else        IRQ <= irq_en & (ovf | empty);
  end
endmodule
